decode_stage: RTL and testbench
===============================

# decode_stage

Pipelined RISC-V instruction field decoder for the decode stage, between the fetch buffer and the register-read / issue logic. Classifies each 32-bit instruction by opcode into a type, extracts register numbers, and builds an XLEN-wide immediate with the existing flag semantics (operand-usage mask, IS_DIFF masking, IS_SIGNED extension). Uses a valid/ready handshake with a 2-entry skid buffer, so the upstream `in_ready` is driven from a register. Compared with the old combinational extractor, it adds parametrised XLEN, opcode-based type decode, illegal detection, back-pressure and flush.

## Interface
- `XLEN`, 32: immediate/data width; 32 or 64.
- `TYPE_WIDTH`, 3: type code width.
- `FLAG_WIDTH`, 16: flag vector width.
- `clk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  discard all buffered instructions.
- `in_valid`  in  1  upstream instruction present.
- `in_ready`  out  1  stage can accept.
- `in_instr`  in  32  raw instruction.
- `in_flag`  in  FLAG_WIDTH  decode hints from fetch.
- `out_valid`  out  1  decoded entry present.
- `out_ready`  in  1  downstream accepts.
- `out_type`  out  TYPE_WIDTH  R/I/S/SB/U/UJ code.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register numbers.
- `out_imm`  out  XLEN  immediate.
- `out_flag`  out  FLAG_WIDTH  output flags.
- `out_illegal`  out  1  unrecognised opcode.

## Operation
- Opcode map, `in_instr[6:0]`:
  - R: 0110011, 0111011.
  - I: 0000011, 0010011, 0011011, 1100111, 1110011.
  - S: 0100011.
  - SB: 1100011.
  - U: 0110111, 0010111.
  - UJ: 1101111.
  - Any other opcode: `out_illegal`=1, `out_type`=R code, `out_imm`=0, `out_flag`=0.
- Register fields: rd=[11:7], rs1=[19:15], rs2=[24:20], always extracted.
- Usage mask, `out_flag[3:0]` (bit0 rd, bit1 rs1, bit2 rs2, bit3 imm):
  - R=0111, I=1011, S=1110, SB=1110, U=1001, UJ=1001.
  - If `in_flag[IS_DIFF_INDEX]`, the mask is ANDed with `in_flag[3:0]`.
- `out_flag[IS_BRACKET_INDEX]` and `out_flag[IS_LOAD_INDEX]` copy the input flag bits. All other flag bits are 0.
- Immediates, with `sx` = `in_flag[IS_SIGNED_INDEX]`:
  - I: `instr[31:20]`. Sign-extended to XLEN if `sx`, otherwise zero-extended from 12 bits.
  - S: `{[31:25],[11:7]}`, extended the same way as I.
  - SB: `{[31],[7],[30:25],[11:8],0}`, 13 bits, extended per `sx`.
  - U: `{[31:12],12'b0}`. Sign-extended from bit 31 when XLEN=64, regardless of `sx`.
  - UJ: `{[31],[19:12],[20],[30:21],0}`, 21 bits, extended per `sx`.
- Skid buffer: main output register plus one skid register. Order is strictly FIFO.

## Timing
- Latency: an instruction accepted in cycle N is visible on the outputs in cycle N+1 at the earliest.
- Handshake:
  - Transfer occurs when valid && ready.
  - `out_*` are held stable while `out_valid` && !`out_ready`.
  - `in_ready` = skid register empty, registered.
- Full throughput: one instruction per cycle when `out_ready` is held high.
- Stall: when the output is stalled and a new instruction is accepted, it goes to the skid register and `in_ready` drops the next cycle. When the output drains, the skid entry moves to the output and `in_ready` rises the next cycle.
- Reset (`reset_n`=0 at an edge): `out_valid`=0, `in_ready`=1, all data outputs 0, perf counters 0. Reset applied mid-stall discards both entries.
- Flush: empties both entries at the edge, giving the same visible state as reset except that counters are kept. An `in_valid` in the flush cycle is dropped. Reset has priority over flush.

## Configuration
- Macro `DECODE_PERF_EN`. When defined, the block adds:
  - `perf_decoded` (out, 32): increments on every output handshake.
  - `perf_illegal` (out, 32): increments on every output handshake with `out_illegal`=1.
  - Both counters wrap modulo 2^32.
- When the macro is undefined, these ports and counters do not exist. Decode behaviour is identical either way.

## Structure
- Package `decode_pkg`:
  - Type codes R_TYPE..UJ_TYPE.
  - Flag indices IS_DIFF_INDEX, IS_SIGNED_INDEX, IS_BRACKET_INDEX, IS_LOAD_INDEX.
  - Opcode constants.
  - Packed struct `decoded_t` (type, rd, rs1, rs2, imm, flag, illegal).
- Sub-module `imm_gen`: purely combinational instruction+type+sx → XLEN immediate, reused by later stages. The skid buffer stays inline.

## Test plan
- 0xFFF10093 with sx=1, XLEN=32 → I, rd=1, rs1=2, imm=0xFFFFFFFF, flag[3:0]=1011. Same instruction with sx=0 → imm=0x00000FFF.
- 0xFE000EE3 with sx=1 → SB, imm=0xFFFFFFFC, flag[3:0]=1110. 0x001000EF with sx=1 → UJ, rd=1, imm=0x00000800.
- 0x123452B7 → U, rd=5, imm=0x12345000. At XLEN=64, 0x800002B7 → imm=0xFFFFFFFF80000000.
- 0x00000000 → `out_illegal`=1, flag=0. With `DECODE_PERF_EN`, `perf_illegal`=1 after the handshake.
- Hold `out_ready`=0 and drive 3 back-to-back valid inputs A, B, C → only A and B accepted, `in_ready`=0 from cycle 2. Release → A, B, C emerge in order with no duplicates.
- Assert `flush` with 2 entries buffered and `in_valid`=1 in the same cycle → next cycle `out_valid`=0, `in_ready`=1, and the flushed-cycle instruction never appears.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and constants for the RISC-V decode stage: type codes, flag bit positions,
// opcodes and the decoded entry carried through the skid buffer.
package decode_pkg;

  localparam int unsigned MAX_XLEN   = 64;
  localparam int unsigned MAX_FLAG_W = 16;

  typedef enum logic [2:0] {
    R_TYPE  = 3'd0,
    I_TYPE  = 3'd1,
    S_TYPE  = 3'd2,
    SB_TYPE = 3'd3,
    U_TYPE  = 3'd4,
    UJ_TYPE = 3'd5
  } instr_type_e;

  // Bits [3:0] of the flag vector hold the operand-usage mask.
  localparam int unsigned IS_DIFF_INDEX    = 4;
  localparam int unsigned IS_SIGNED_INDEX  = 5;
  localparam int unsigned IS_BRACKET_INDEX = 6;
  localparam int unsigned IS_LOAD_INDEX    = 7;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  typedef logic [MAX_XLEN-1:0] imm_t;

  typedef struct packed {
    instr_type_e             itype;
    logic [4:0]              rd;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    imm_t                    imm;
    logic [MAX_FLAG_W-1:0]   flag;
    logic                    illegal;
  } decoded_t;

  // Operand-usage mask: bit0 rd, bit1 rs1, bit2 rs2, bit3 imm.
  function automatic logic [3:0] usage_mask(instr_type_e t);
    unique case (t)
      R_TYPE:  return 4'b0111;
      I_TYPE:  return 4'b1011;
      S_TYPE:  return 4'b1110;
      SB_TYPE: return 4'b1110;
      U_TYPE:  return 4'b1001;
      UJ_TYPE: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: instruction + type + signed hint -> XLEN immediate.
// U-type always sign-extends from bit 31; other formats extend only when sx_i is set.
module imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  instr_type_e     type_i,
  input  logic            sx_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] lo;
  logic        fill;
  logic        s;

  assign s = sx_i & instr_i[31];

  always_comb begin
    lo   = '0;
    fill = 1'b0;
    unique case (type_i)
      I_TYPE: begin
        lo   = {{20{s}}, instr_i[31:20]};
        fill = s;
      end
      S_TYPE: begin
        lo   = {{20{s}}, instr_i[31:25], instr_i[11:7]};
        fill = s;
      end
      SB_TYPE: begin
        lo   = {{19{s}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        fill = s;
      end
      U_TYPE: begin
        lo   = {instr_i[31:12], 12'b0};
        fill = instr_i[31];
      end
      UJ_TYPE: begin
        lo   = {{11{s}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        fill = s;
      end
      default: ;
    endcase
  end

  if (XLEN > 32) begin : g_wide
    assign imm_o = {{(XLEN-32){fill}}, lo};
  end else begin : g_narrow
    logic unused_fill;
    assign unused_fill = fill;
    assign imm_o       = lo[XLEN-1:0];
  end

  logic unused_opc;
  assign unused_opc = ^instr_i[6:0];

endmodule

// File: rtl/decode_stage.sv
// Pipelined RISC-V field decoder with a 2-entry skid buffer and registered in_ready.
// Optional perf counters are built when DECODE_PERF_EN is defined.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TYPE_WIDTH = 3,
  parameter int unsigned FLAG_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [FLAG_WIDTH-1:0] in_flag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TYPE_WIDTH-1:0] out_type,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [XLEN-1:0]       out_imm,
  output logic [FLAG_WIDTH-1:0] out_flag,
  output logic                  out_illegal
`ifdef DECODE_PERF_EN
 ,output logic [31:0]           perf_decoded,
  output logic [31:0]           perf_illegal
`endif
);

  // ---------------------------------------------------------------------------
  // Field decode
  // ---------------------------------------------------------------------------
  instr_type_e     itype;
  logic            legal;
  logic [XLEN-1:0] imm_w;
  logic [3:0]      mask;
  decoded_t        dec;

  always_comb begin
    itype = R_TYPE;
    legal = 1'b1;
    unique case (in_instr[6:0])
      OPC_OP, OPC_OP_32:                                         itype = R_TYPE;
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM: itype = I_TYPE;
      OPC_STORE:                                                 itype = S_TYPE;
      OPC_BRANCH:                                                itype = SB_TYPE;
      OPC_LUI, OPC_AUIPC:                                        itype = U_TYPE;
      OPC_JAL:                                                   itype = UJ_TYPE;
      default:                                                   legal = 1'b0;
    endcase
  end

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr_i (in_instr),
    .type_i  (itype),
    .sx_i    (in_flag[IS_SIGNED_INDEX]),
    .imm_o   (imm_w)
  );

  always_comb begin
    mask = usage_mask(itype);
    if (in_flag[IS_DIFF_INDEX]) mask = mask & in_flag[3:0];

    dec         = '0;
    dec.itype   = itype;
    dec.rd      = in_instr[11:7];
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.illegal = !legal;
    if (legal) begin
      dec.imm                    = imm_t'(imm_w);
      dec.flag[3:0]              = mask;
      dec.flag[IS_BRACKET_INDEX] = in_flag[IS_BRACKET_INDEX];
      dec.flag[IS_LOAD_INDEX]    = in_flag[IS_LOAD_INDEX];
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer: main_q drives the outputs, skid_q catches one entry during a stall
  // ---------------------------------------------------------------------------
  decoded_t main_q, main_d, skid_q, skid_d;
  logic     main_valid_q, main_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     in_ready_q, in_ready_d;
  logic     accept, out_fire;

  assign accept   = in_valid && in_ready_q;
  assign out_fire = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      // in_ready_q is low here, so nothing new can arrive.
      if (out_fire) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || out_fire) begin
      main_valid_d = accept;
      if (accept) main_d = dec;
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_type    = TYPE_WIDTH'(main_q.itype);
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_imm     = main_q.imm[XLEN-1:0];
  assign out_flag    = main_q.flag[FLAG_WIDTH-1:0];
  assign out_illegal = main_q.illegal;

  // Upper imm/flag bits of the shared struct are unused for narrow configurations.
  logic unused_main;
  assign unused_main = ^main_q;

`ifdef DECODE_PERF_EN
  logic [31:0] perf_decoded_q, perf_illegal_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_decoded_q <= '0;
      perf_illegal_q <= '0;
    end else if (out_fire) begin
      perf_decoded_q <= perf_decoded_q + 32'd1;
      if (main_q.illegal) perf_illegal_q <= perf_illegal_q + 32'd1;
    end
  end

  assign perf_decoded = perf_decoded_q;
  assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field decode, immediates (XLEN 32 and 64), handshake,
// stall/skid ordering, flush and reset. Perf counters are checked when DECODE_PERF_EN is set.
module tb_decode_stage;

  localparam logic [15:0] F_DIFF = 16'h0010;
  localparam logic [15:0] F_SX   = 16'h0020;
  localparam logic [15:0] F_BRK  = 16'h0040;
  localparam logic [15:0] F_LOAD = 16'h0080;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [15:0] in_flag = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_illegal;
  logic [2:0]  out_type;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic [15:0] out_flag;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [2:0]  out_type64;
  logic [4:0]  out_rd64, out_rs164, out_rs264;
  logic [63:0] out_imm64;
  logic [15:0] out_flag64;

`ifdef DECODE_PERF_EN
  logic [31:0] perf_decoded, perf_illegal, perf_decoded64, perf_illegal64;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_flag(in_flag), .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_flag(out_flag), .out_illegal(out_illegal)
`ifdef DECODE_PERF_EN
   ,.perf_decoded(perf_decoded), .perf_illegal(perf_illegal)
`endif
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_flag(in_flag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_type(out_type64), .out_rd(out_rd64), .out_rs1(out_rs164), .out_rs2(out_rs264),
    .out_imm(out_imm64), .out_flag(out_flag64), .out_illegal(out_illegal64)
`ifdef DECODE_PERF_EN
   ,.perf_decoded(perf_decoded64), .perf_illegal(perf_illegal64)
`endif
  );

  // Present one instruction for a single accept edge; outputs are sampled 1ns later.
  task automatic send(input logic [31:0] instr, input logic [15:0] flag);
    in_instr = instr;
    in_flag  = flag;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %h exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %h exp 1", in_ready); end
    checks++; if ({out_type, out_rd, out_rs1, out_rs2, out_imm, out_flag, out_illegal} !== '0) begin
      errors++; $display("FAIL reset_data got imm=%h flag=%h rd=%h exp all 0", out_imm, out_flag, out_rd); end
`ifdef DECODE_PERF_EN
    checks++; if ({perf_decoded, perf_illegal} !== 64'd0) begin errors++; $display("FAIL reset_perf got %h/%h exp 0/0", perf_decoded, perf_illegal); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_itype();
    send(32'hFFF10093, F_SX);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL i_valid got %h exp 1", out_valid); end
    checks++; if (out_type !== 3'd1) begin errors++; $display("FAIL i_type got %h exp 1", out_type); end
    checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd2) begin errors++; $display("FAIL i_regs got rd=%0d rs1=%0d exp 1/2", out_rd, out_rs1); end
    checks++; if (out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL i_imm_sx got %h exp FFFFFFFF", out_imm); end
    checks++; if (out_imm64 !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL i_imm64_sx got %h exp all ones", out_imm64); end
    checks++; if (out_flag !== 16'h000B) begin errors++; $display("FAIL i_flag got %h exp 000B", out_flag); end
    send(32'hFFF10093, 16'h0000);
    checks++; if (out_imm !== 32'h00000FFF) begin errors++; $display("FAIL i_imm_zx got %h exp 00000FFF", out_imm); end
    checks++; if (out_imm64 !== 64'h0000000000000FFF) begin errors++; $display("FAIL i_imm64_zx got %h exp FFF", out_imm64); end
  endtask

  task automatic test_branch_jump();
    send(32'hFE000EE3, F_SX);
    checks++; if (out_type !== 3'd3) begin errors++; $display("FAIL sb_type got %h exp 3", out_type); end
    checks++; if (out_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL sb_imm got %h exp FFFFFFFC", out_imm); end
    checks++; if (out_flag !== 16'h000E) begin errors++; $display("FAIL sb_flag got %h exp 000E", out_flag); end
    send(32'h001000EF, F_SX);
    checks++; if (out_type !== 3'd5 || out_rd !== 5'd1) begin errors++; $display("FAIL uj_type_rd got %h/%0d exp 5/1", out_type, out_rd); end
    checks++; if (out_imm !== 32'h00000800) begin errors++; $display("FAIL uj_imm got %h exp 00000800", out_imm); end
    checks++; if (out_flag !== 16'h0009) begin errors++; $display("FAIL uj_flag got %h exp 0009", out_flag); end
  endtask

  task automatic test_utype();
    send(32'h123452B7, 16'h0000);
    checks++; if (out_type !== 3'd4 || out_rd !== 5'd5) begin errors++; $display("FAIL u_type_rd got %h/%0d exp 4/5", out_type, out_rd); end
    checks++; if (out_imm !== 32'h12345000) begin errors++; $display("FAIL u_imm got %h exp 12345000", out_imm); end
    send(32'h800002B7, 16'h0000);
    checks++; if (out_imm !== 32'h80000000) begin errors++; $display("FAIL u_imm_neg got %h exp 80000000", out_imm); end
    checks++; if (out_imm64 !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL u_imm64_neg got %h exp FFFFFFFF80000000", out_imm64); end
  endtask

  task automatic test_store_rtype();
    // sw x1,-4(x2) with diff mask 0011, bracket and load hints.
    send(32'hFE112E23, F_SX | F_DIFF | F_BRK | F_LOAD | 16'h0003);
    checks++; if (out_type !== 3'd2 || out_rs1 !== 5'd2 || out_rs2 !== 5'd1) begin
      errors++; $display("FAIL s_fields got t=%h rs1=%0d rs2=%0d exp 2/2/1", out_type, out_rs1, out_rs2); end
    checks++; if (out_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL s_imm_sx got %h exp FFFFFFFC", out_imm); end
    checks++; if (out_flag !== 16'h00C2) begin errors++; $display("FAIL s_flag_diff got %h exp 00C2", out_flag); end
    send(32'hFE112E23, 16'h0000);
    checks++; if (out_imm !== 32'h00000FFC) begin errors++; $display("FAIL s_imm_zx got %h exp 00000FFC", out_imm); end
    send(32'h002081B3, F_SX);
    checks++; if (out_type !== 3'd0 || out_rd !== 5'd3 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin
      errors++; $display("FAIL r_fields got t=%h rd=%0d rs1=%0d rs2=%0d exp 0/3/1/2", out_type, out_rd, out_rs1, out_rs2); end
    checks++; if (out_imm !== 32'h0 || out_flag !== 16'h0007 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL r_imm_flag got imm=%h flag=%h ill=%h exp 0/0007/0", out_imm, out_flag, out_illegal); end
  endtask

  task automatic test_illegal();
    send(32'h00000000, F_SX | F_BRK | F_LOAD);
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %h exp 1", out_illegal); end
    checks++; if (out_flag !== 16'h0 || out_imm !== 32'h0 || out_type !== 3'd0) begin
      errors++; $display("FAIL ill_data got flag=%h imm=%h type=%h exp 0/0/0", out_flag, out_imm, out_type); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill_drain got %h exp 0", out_valid); end
`ifdef DECODE_PERF_EN
    checks++; if (perf_illegal !== 32'd1) begin errors++; $display("FAIL perf_illegal got %0d exp 1", perf_illegal); end
    checks++; if (perf_decoded !== 32'd10) begin errors++; $display("FAIL perf_decoded got %0d exp 10", perf_decoded); end
`endif
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_flag   = '0;
    in_instr  = 32'h000000B3; in_valid = 1'b1;  // A, rd=1
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_a got v=%h rd=%0d rdy=%h exp 1/1/1", out_valid, out_rd, in_ready); end
    in_instr = 32'h00000133;  // B, rd=2
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0 || out_rd !== 5'd1) begin
      errors++; $display("FAIL stall_b got rdy=%h rd=%0d exp 0/1", in_ready, out_rd); end
    in_instr = 32'h000001B3;  // C, rd=3, held until accepted
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== 5'd1) begin
      errors++; $display("FAIL stall_hold got rdy=%h v=%h rd=%0d exp 0/1/1", in_ready, out_valid, out_rd); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd2 || in_ready !== 1'b1) begin
      errors++; $display("FAIL drain_b got v=%h rd=%0d rdy=%h exp 1/2/1", out_valid, out_rd, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd3) begin
      errors++; $display("FAIL drain_c got v=%h rd=%0d exp 1/3", out_valid, out_rd); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %h exp 0", out_valid); end
`ifdef DECODE_PERF_EN
    checks++; if (perf_decoded !== 32'd13) begin errors++; $display("FAIL perf_b2b got %0d exp 13", perf_decoded); end
`endif
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h00000233, 16'h0000);  // rd=4
    send(32'h000002B3, 16'h0000);  // rd=5, lands in skid
    in_instr = 32'h00000333; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state got v=%h rdy=%h exp 0/1", out_valid, in_ready); end
    checks++; if (out_rd !== 5'd0 || out_imm !== 32'h0 || out_flag !== 16'h0) begin
      errors++; $display("FAIL flush_data got rd=%0d imm=%h flag=%h exp 0", out_rd, out_imm, out_flag); end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got %h exp 0", out_valid); end
    // in_valid on an empty stage during flush is dropped.
    in_instr = 32'h000003B3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %h exp 0", out_valid); end
`ifdef DECODE_PERF_EN
    checks++; if (perf_decoded !== 32'd13) begin errors++; $display("FAIL perf_flush_kept got %0d exp 13", perf_decoded); end
`endif
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    send(32'h00000233, 16'h0000);
    send(32'h000002B3, 16'h0000);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_full got %h exp 0", in_ready); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_rd !== 5'd0) begin
      errors++; $display("FAIL rst_stall got v=%h rdy=%h rd=%0d exp 0/1/0", out_valid, in_ready, out_rd); end
`ifdef DECODE_PERF_EN
    checks++; if (perf_decoded !== 32'd0) begin errors++; $display("FAIL rst_perf got %0d exp 0", perf_decoded); end
`endif
    reset_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_ghost got %h exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_branch_jump();
    test_utype();
    test_store_rtype();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
